// File: rtl/axi_wr_route_ctrl.sv
// Write-channel routing controller: tracks one AXI write (AW, W, B) at a time and acts as default slave on decode error.
// Optional burst-length checking is enabled by defining WLAST_CHECK_EN.
module axi_wr_route_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             awvalid,
  input  logic             awready,
  input  logic [LEN_W-1:0] awlen,
  input  logic             decerr,
  input  logic             wvalid,
  input  logic             wready,
  input  logic             wlast,
  input  logic             bvalid,
  input  logic             bready,
  output logic             route_w,
  output logic             route_b,
  output logic             err_awready,
  output logic             err_wready,
  output logic             err_bvalid,
  output logic [1:0]       err_bresp,
  output logic             decoderrst,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             protocol_err
);

  typedef enum logic [2:0] {
    RST   = 3'b111,
    IDLE  = 3'b000,
    WDATA = 3'b001,
    WRESP = 3'b010,
    ERRW  = 3'b011,
    ERRB  = 3'b100
  } state_t;

  state_t state, state_nxt;
  logic   aw_take;
  logic   w_beat;

  always_ff @(posedge clk) begin
    if (rst) state <= RST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    route_w     = 1'b0;
    route_b     = 1'b0;
    err_awready = 1'b0;
    err_wready  = 1'b0;
    err_bvalid  = 1'b0;
    decoderrst  = 1'b0;
    aw_take     = 1'b0;
    w_beat      = 1'b0;
    case (state)
      RST: begin
        decoderrst = 1'b1;
        state_nxt  = IDLE;
      end
      IDLE: begin
        // Decode error takes priority: the default slave answers whatever the real slaves do.
        if (awvalid && decerr) begin
          err_awready = 1'b1;
          aw_take     = 1'b1;
          state_nxt   = ERRW;
        end else if (awvalid && awready) begin
          aw_take   = 1'b1;
          state_nxt = WDATA;
        end
      end
      WDATA: begin
        route_w = 1'b1;
        if (wvalid && wready) begin
          w_beat = 1'b1;
          if (wlast) state_nxt = WRESP;
        end
      end
      WRESP: begin
        route_b = 1'b1;
        if (bvalid && bready) begin
          decoderrst = 1'b1;
          state_nxt  = IDLE;
        end
      end
      ERRW: begin
        err_wready = 1'b1;
        if (wvalid) begin
          w_beat = 1'b1;
          if (wlast) state_nxt = ERRB;
        end
      end
      ERRB: begin
        err_bvalid = 1'b1;
        if (bready) begin
          decoderrst = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = RST;
    endcase
  end

  assign err_bresp = 2'b11;

  always_ff @(posedge clk) begin
    if (rst)          beat_cnt <= '0;
    else if (aw_take) beat_cnt <= '0;
    else if (w_beat)  beat_cnt <= beat_cnt + 1'b1;
  end

`ifdef WLAST_CHECK_EN
  logic [LEN_W-1:0] awlen_cap;

  // wlast must coincide exactly with the beat whose zero-based index equals awlen.
  function automatic logic len_mismatch(input logic last, input logic [LEN_W-1:0] cnt,
                                        input logic [LEN_W-1:0] len);
    return last ? (cnt != len) : (cnt == len);
  endfunction

  always_ff @(posedge clk) begin
    if (aw_take) awlen_cap <= awlen;
  end

  always_ff @(posedge clk) begin
    if (rst)                                                protocol_err <= 1'b0;
    else if (w_beat && len_mismatch(wlast, beat_cnt, awlen_cap)) protocol_err <= 1'b1;
  end
`else
  logic unused_awlen;
  assign unused_awlen = ^awlen;
  assign protocol_err = 1'b0;
`endif

endmodule

// File: doc/axi_wr_route_ctrl.md
# axi_wr_route_ctrl

Write-channel routing controller for the AXI interconnect. It tracks one write transaction at a time through AW, W and B. It gates W and B routing to the slave selected by the address decoder, and pulses the decoder reset when the transaction ends. On an address decode error it acts as the default slave: it accepts AW, sinks the W burst and returns a DECERR response on B.

## Interface
- LEN_W, 8, width of awlen and of the beat counter.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- awvalid  in  1  master AW valid.
- awready  in  1  AW ready from the selected slave.
- awlen  in  LEN_W  burst length minus one; sampled on AW handshake.
- decerr  in  1  decoder flag: the AW address matches no slave.
- wvalid  in  1  master W valid.
- wready  in  1  W ready from the selected slave, already gated by route_w.
- wlast  in  1  master W last.
- bvalid  in  1  B valid from the selected slave.
- bready  in  1  master B ready.
- route_w  out  1  enable W path master↔selected slave.
- route_b  out  1  enable B path selected slave→master.
- err_awready  out  1  default-slave AW ready.
- err_wready  out  1  default-slave W ready.
- err_bvalid  out  1  default-slave B valid.
- err_bresp  out  2  default-slave response; fixed 2'b11 (DECERR).
- decoderrst  out  1  one-cycle reset pulse to the address decoder.
- beat_cnt  out  LEN_W  W beats accepted in the current burst.
- protocol_err  out  1  sticky burst-length mismatch flag (see Configuration).

## Operation
- States: RST, IDLE, WDATA, WRESP, ERRW, ERRB. Encoding is 3 bits, with RST = 3'b111.
- RST: decoderrst=1. Goes to IDLE unconditionally.
- IDLE:
  - awvalid&&awready&&!decerr → WDATA. Capture awlen; clear beat_cnt.
  - awvalid&&decerr → err_awready=1 (combinational, this cycle only) and go to ERRW. Capture awlen; clear beat_cnt.
  - Otherwise stay in IDLE.
  - W is never routed in IDLE. A W beat presented before AW waits.
- WDATA: route_w=1.
  - Each wvalid&&wready increments beat_cnt.
  - A handshake with wlast=1 → WRESP.
- WRESP: route_b=1.
  - bvalid&&bready → IDLE, with decoderrst=1 in that same cycle (Mealy).
- ERRW: err_wready=1.
  - Each wvalid increments beat_cnt.
  - wvalid&&wlast → ERRB.
- ERRB: err_bvalid=1, err_bresp=2'b11.
  - bready → IDLE, with decoderrst=1 in that same cycle.
- Outputs are mutually exclusive: route_w, route_b, err_wready and err_bvalid are never high together.
- err_bresp is constant 2'b11. It is only meaningful while err_bvalid=1.
- beat_cnt wraps modulo 2^LEN_W. It holds its value after the burst until the next AW handshake.

## Timing
- While rst=1 the next state is forced to RST. The first cycle after release is RST (decoderrst=1); the cycle after that is IDLE.
- Output values in the RST state:
  - decoderrst=1.
  - All route/err outputs 0.
  - beat_cnt=0.
  - protocol_err=0.
- AW handshake to route_w: 1 cycle. The first W beat can complete in the cycle after the AW handshake.
- Last W handshake to route_b/err_bvalid: 1 cycle.
- B handshake to the next AW acceptance: 1 cycle (IDLE).
- A single-beat burst (awlen=0) takes 4 cycles minimum: AW, W, B, IDLE.
- rst asserted mid-transaction aborts it. Routing drops at the next edge, and no B response is generated for the aborted burst.
- An awvalid that drops while in IDLE causes no state change.

## Configuration
- WLAST_CHECK_EN, when defined:
  - On each W beat (WDATA or ERRW), protocol_err is set if wlast=1 while beat_cnt≠captured awlen.
  - protocol_err is also set if wlast=0 while beat_cnt==awlen.
  - protocol_err is sticky until rst.
  - The FSM still ends the burst only on wlast.
- Without WLAST_CHECK_EN: protocol_err is tied to 0 and awlen is not stored.

## Test plan
- Reset release → decoderrst=1 for exactly one cycle, then IDLE with all outputs 0.
- Good burst, awlen=3: AW handshake, 4 W beats with wlast on the 4th, bvalid&&bready → route_w for exactly 4 beats, beat_cnt=4, route_b for 1 cycle, decoderrst pulse on the B-handshake cycle.
- Decode error, awlen=1: awvalid with decerr=1 → err_awready=1; 2 W beats sunk via err_wready; err_bvalid=1 with err_bresp=2'b11 held until bready; then decoderrst pulse.
- Back-pressure: wready low for 3 cycles mid-burst, then bready low for 2 cycles → beat_cnt unchanged while stalled; err/route outputs hold; no early IDLE.
- rst asserted in WDATA after 2 beats → next cycle RST; route_w=0; beat_cnt=0; no B.
- WLAST_CHECK_EN defined, awlen=3, wlast on beat 2 → protocol_err=1, FSM goes to WRESP; protocol_err stays 1 through the next good burst.
